// File: rtl/lcd_host_seq_pkg.sv
// ----------------------------------------------------------------------------
// lcd_pkg
//   Shared definitions for the LCD host sequencer: controller command codes,
//   image geometry, datapath widths, the sequencer FSM encoding and the
//   checksum helper.
// ----------------------------------------------------------------------------
package lcd_pkg;

  // Controller command codes
  localparam logic [2:0] CMD_WRITE    = 3'd0;
  localparam logic [2:0] CMD_UP       = 3'd1;
  localparam logic [2:0] CMD_DOWN     = 3'd2;
  localparam logic [2:0] CMD_LEFT     = 3'd3;
  localparam logic [2:0] CMD_RIGHT    = 3'd4;
  localparam logic [2:0] CMD_AVERAGE  = 3'd5;
  localparam logic [2:0] CMD_MIRROR_X = 3'd6;
  localparam logic [2:0] CMD_MIRROR_Y = 3'd7;

  // Image geometry: 8x8 pixels, one byte each
  localparam int IMG_W      = 8;
  localparam int IMG_H      = 8;
  localparam int IMG_PIXELS = IMG_W * IMG_H;
  localparam int ADDR_W     = $clog2(IMG_PIXELS);

  // Datapath widths
  localparam int CMD_W  = 3;
  localparam int DATA_W = 8;
  localparam int CHK_W  = 14;
  localparam int TMO_W  = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RDY,
    ST_ISSUE,
    ST_GUARD,
    ST_WAIT_BUSY,
    ST_CAPTURE,
    ST_FIN
  } state_e;

  // Running checksum: byte added into a CHK_W-bit accumulator, wrapping.
  function automatic logic [CHK_W-1:0] chk_add(input logic [CHK_W-1:0] acc,
                                               input logic [DATA_W-1:0] data);
    return acc + CHK_W'(data);
  endfunction

endpackage

// File: rtl/lcd_host_seq_if.sv
// ----------------------------------------------------------------------------
// lcd_host_seq_if
//   Host <-> LCD controller signals: the command handshake and the IRB
//   image-write port.
//   master : host side   (drives cmd/cmd_valid, receives busy/done/IRB_*)
//   slave  : controller  (the reverse)
// ----------------------------------------------------------------------------
interface lcd_host_seq_if;
  import lcd_pkg::*;

  logic [CMD_W-1:0]  cmd;        // command code
  logic              cmd_valid;  // one-cycle command strobe
  logic              busy;       // controller busy
  logic              done;       // controller finished writing the image
  logic              IRB_RW;     // IRB write strobe, active low
  logic [DATA_W-1:0] IRB_D;      // IRB write data
  logic [ADDR_W-1:0] IRB_A;      // IRB write address

  modport master (
    output cmd, cmd_valid,
    input  busy, done, IRB_RW, IRB_D, IRB_A
  );

  modport slave (
    input  cmd, cmd_valid,
    output busy, done, IRB_RW, IRB_D, IRB_A
  );

endinterface

// File: rtl/lcd_cmd_fifo.sv
// ----------------------------------------------------------------------------
// lcd_cmd_fifo
//   Synchronous FIFO of 3-bit command codes, DEPTH entries (power of 2).
//   Pushes while full and pops while empty are ignored. The head entry is
//   presented combinationally on dout_o.
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     push_i, din_i     write request and data
//     pop_i, dout_o     read request and head-of-queue data
//     full_o, empty_o   status
//     count_o           current occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module lcd_cmd_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [2:0]             din_i,
  input  logic                   pop_i,
  output logic [2:0]             dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i  && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; the pointers and count
  // define which entries are valid, so clearing the array buys nothing.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/lcd_host_seq.sv
// ----------------------------------------------------------------------------
// lcd_host_seq
//   Host-side initiator for the LCD controller. Buffers a command script,
//   issues it over the cmd/cmd_valid/busy handshake (auto-appending a final
//   write), then captures the 64-byte image written over IRB into a local
//   frame buffer while accumulating a checksum.
//   Ports:
//     clk, reset            clock, asynchronous active-high reset
//     q_wr, q_cmd           push a command code into the script queue
//     start                 one-cycle pulse, begins issuing (IDLE only)
//     bus (master)          cmd/cmd_valid/busy/done and IRB write port
//     rd_addr, rd_data      frame buffer read, registered, 1-cycle latency
//     frame_valid           image fully captured (held until reset)
//     checksum              sum of captured IRB bytes, mod 2^14
//     q_full                script queue full
//     error                 sticky: queue overflow, timeout, stray IRB write
// ----------------------------------------------------------------------------
module lcd_host_seq
  import lcd_pkg::*;
#(
  parameter int QDEPTH  = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               q_wr,
  input  logic [CMD_W-1:0]   q_cmd,
  input  logic               start,
  lcd_host_seq_if.master     bus,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0]  rd_data,
  output logic               frame_valid,
  output logic [CHK_W-1:0]   checksum,
  output logic               q_full,
  output logic               error
);

  localparam int QCW = $clog2(QDEPTH) + 1;

  state_e            state_q, state_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [CHK_W-1:0]  chk_q, chk_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rd_data_q;

  logic              fifo_pop;
  logic [CMD_W-1:0]  fifo_head;
  logic              fifo_full, fifo_empty;
  logic [QCW-1:0]    fifo_count;

  logic              irb_wr;
  logic              tmo_hit;
  logic              fb_we;
  logic [DATA_W-1:0] fb_mem [IMG_PIXELS];

  lcd_cmd_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (q_wr),
    .din_i   (q_cmd),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign irb_wr  = !bus.IRB_RW;
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT));

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    tmo_d    = tmo_q;
    chk_d    = chk_q;
    err_d    = err_q;
    fifo_pop = 1'b0;
    fb_we    = 1'b0;

    // Overflowing push: the FIFO drops the entry, we flag it.
    if (q_wr && fifo_full) err_d = 1'b1;

    // The controller must only write the image while we are capturing.
    if (irb_wr && (state_q != ST_CAPTURE)) err_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_WAIT_RDY;
      end

      // Also absorbs the controller's initial image load after reset.
      ST_WAIT_RDY: begin
        if (!bus.busy) begin
          if (!fifo_empty) begin
            cmd_d    = fifo_head;
            fifo_pop = 1'b1;
          end else begin
            cmd_d = CMD_WRITE;
          end
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        tmo_d   = '0;
        state_d = (cmd_q == CMD_WRITE) ? ST_CAPTURE : ST_GUARD;
      end

      // The controller raises busy one cycle after sampling cmd_valid, so
      // busy is not trusted here.
      ST_GUARD: begin
        state_d = ST_WAIT_BUSY;
      end

      ST_WAIT_BUSY: begin
        if (!bus.busy) begin
          state_d = ST_WAIT_RDY;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else if (tmo_q != '1) begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      // A write in the same cycle as done is still captured.
      ST_CAPTURE: begin
        if (irb_wr) begin
          fb_we = 1'b1;
          chk_d = chk_add(chk_q, bus.IRB_D);
        end
        if (bus.done) begin
          state_d = ST_FIN;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else if (tmo_q != '1) begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      ST_FIN: begin
        state_d = ST_FIN;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_WRITE;
      tmo_q   <= '0;
      chk_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      tmo_q   <= tmo_d;
      chk_q   <= chk_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame buffer: captured image survives reset; read port is registered.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (fb_we) fb_mem[bus.IRB_A] <= bus.IRB_D;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= fb_mem[rd_addr];
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // cmd_valid decodes a registered state, so it is a clean single-cycle pulse
  // and ISSUE is only reached from WAIT_RDY after busy was seen low.
  assign bus.cmd       = cmd_q;
  assign bus.cmd_valid = (state_q == ST_ISSUE);
  assign rd_data       = rd_data_q;
  assign frame_valid   = (state_q == ST_FIN);
  assign checksum      = chk_q;
  assign error         = err_q;
  // Full is reported from the occupancy count; overflow detection above uses
  // the FIFO's own full flag, which is the same condition.
  assign q_full        = (fifo_count == QCW'(QDEPTH));

endmodule

// File: tb/tb_lcd_host_seq.sv
// ----------------------------------------------------------------------------
// tb_lcd_host_seq
//   Directed bench for lcd_host_seq. The bench plays the LCD controller
//   (busy/done/IRB) and checks the command stream, capture, checksum, queue
//   overflow, timeout, stray-write and mid-run reset behaviour.
// ----------------------------------------------------------------------------
module tb_lcd_host_seq;
  import lcd_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        q_wr;
  logic [2:0]  q_cmd;
  logic        start;
  logic [5:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        frame_valid;
  logic [13:0] checksum;
  logic        q_full;
  logic        error;

  int tests = 0;
  int fails = 0;
  int cnt;

  always #5 clk = ~clk;

  lcd_host_seq_if bus_if ();

  lcd_host_seq #(.QDEPTH(16), .TIMEOUT(1023)) dut (
    .clk         (clk),
    .reset       (reset),
    .q_wr        (q_wr),
    .q_cmd       (q_cmd),
    .start       (start),
    .bus         (bus_if),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_valid (frame_valid),
    .checksum    (checksum),
    .q_full      (q_full),
    .error       (error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [2:0] c);
    q_wr  = 1'b1;
    q_cmd = c;
    @(negedge clk);
    q_wr  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic irb_write(input logic [5:0] a, input logic [7:0] d, input logic last);
    bus_if.IRB_RW = 1'b0;
    bus_if.IRB_A  = a;
    bus_if.IRB_D  = d;
    bus_if.done   = last;
    @(negedge clk);
    bus_if.IRB_RW = 1'b1;
    bus_if.done   = 1'b0;
  endtask

  // Waits for a cmd_valid pulse, checks code/busy/pulse width, then acts as
  // the controller: optionally raises busy the cycle after sampling cmd_valid
  // and drops it again after 'hold' cycles (hold == 0 leaves busy as is).
  task automatic wait_cmd(input logic [2:0] exp, input string tag,
                          input bit raise, input int hold);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus_if.cmd_valid === 1'b1) seen = 1'b1;
    end
    check({tag, "_seen"}, 32'(seen), 1);
    check({tag, "_cmd"}, 32'(bus_if.cmd), 32'(exp));
    check({tag, "_busy_low"}, 32'(bus_if.busy), 0);
    @(negedge clk);
    check({tag, "_one_cycle"}, 32'(bus_if.cmd_valid), 0);
    if (raise) bus_if.busy = 1'b1;
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      bus_if.busy = 1'b0;
    end
  endtask

  initial begin
    reset         = 1'b1;
    q_wr          = 1'b0;
    q_cmd         = 3'd0;
    start         = 1'b0;
    rd_addr       = 6'd0;
    bus_if.busy   = 1'b1;
    bus_if.done   = 1'b0;
    bus_if.IRB_RW = 1'b1;
    bus_if.IRB_D  = 8'd0;
    bus_if.IRB_A  = 6'd0;

    // ---- reset values -------------------------------------------------------
    tick(2);
    check("rst_cmd",         32'(bus_if.cmd),       0);
    check("rst_cmd_valid",   32'(bus_if.cmd_valid), 0);
    check("rst_rd_data",     32'(rd_data),          0);
    check("rst_frame_valid", 32'(frame_valid),      0);
    check("rst_checksum",    32'(checksum),         0);
    check("rst_error",       32'(error),            0);
    check("rst_q_full",      32'(q_full),           0);
    reset = 1'b0;
    tick(1);

    // ---- T1: script 4,1,5 issued only after the initial busy drops ---------
    push(CMD_RIGHT);
    push(CMD_UP);
    push(CMD_AVERAGE);
    pulse_start();
    cnt = 0;
    repeat (70) begin
      @(negedge clk);
      if (bus_if.cmd_valid) cnt++;
    end
    check("t1_no_cmd_while_busy", 32'(cnt), 0);
    bus_if.busy = 1'b0;
    wait_cmd(CMD_RIGHT,   "t1_c0",   1'b1, 4);
    wait_cmd(CMD_UP,      "t1_c1",   1'b1, 4);
    wait_cmd(CMD_AVERAGE, "t1_c2",   1'b1, 4);
    wait_cmd(CMD_WRITE,   "t1_auto", 1'b0, 0);

    // ---- T6: partial capture, then reset mid-CAPTURE -----------------------
    push(CMD_DOWN);
    push(CMD_LEFT);
    for (int i = 0; i < 10; i++) irb_write(6'(i), 8'd3, 1'b0);
    check("t6_partial_checksum", 32'(checksum),    30);
    check("t6_partial_fv",       32'(frame_valid), 0);
    check("t6_partial_error",    32'(error),       0);
    reset = 1'b1;
    tick(1);
    check("t6_rst_cmd_valid",   32'(bus_if.cmd_valid), 0);
    check("t6_rst_cmd",         32'(bus_if.cmd),       0);
    check("t6_rst_checksum",    32'(checksum),         0);
    check("t6_rst_frame_valid", 32'(frame_valid),      0);
    check("t6_rst_error",       32'(error),            0);
    check("t6_rst_q_full",      32'(q_full),           0);
    check("t6_rst_rd_data",     32'(rd_data),          0);
    reset = 1'b0;
    tick(1);
    pulse_start();
    // Queue was cleared by reset, so the only command is the appended write.
    wait_cmd(CMD_WRITE, "t6_auto", 1'b0, 0);

    // ---- T2: full 64-byte capture of value 2 -------------------------------
    do_reset();
    push(CMD_WRITE);
    pulse_start();
    wait_cmd(CMD_WRITE, "t2_cmd", 1'b0, 0);
    for (int i = 0; i < 63; i++) irb_write(6'(i), 8'd2, 1'b0);
    check("t2_fv_before_done", 32'(frame_valid), 0);
    irb_write(6'd63, 8'd2, 1'b1);
    check("t2_frame_valid", 32'(frame_valid), 1);
    check("t2_checksum",    32'(checksum),    128);
    check("t2_error",       32'(error),       0);
    rd_addr = 6'd63;
    tick(1);
    check("t2_rd63", 32'(rd_data), 2);
    rd_addr = 6'd0;
    tick(1);
    check("t2_rd0", 32'(rd_data), 2);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus_if.cmd_valid) cnt++;
    end
    check("t2_no_cmd_after_fin", 32'(cnt), 0);

    // ---- T5: stray IRB write during WAIT_BUSY ------------------------------
    do_reset();
    push(CMD_DOWN);
    pulse_start();
    wait_cmd(CMD_DOWN, "t5_cmd", 1'b1, 0);
    tick(1);
    check("t5_error_before", 32'(error), 0);
    irb_write(6'd63, 8'h55, 1'b0);
    check("t5_error_after", 32'(error), 1);
    bus_if.busy = 1'b0;
    wait_cmd(CMD_WRITE, "t5_auto", 1'b0, 0);
    bus_if.done = 1'b1;
    tick(1);
    bus_if.done = 1'b0;
    check("t5_frame_valid", 32'(frame_valid), 1);
    check("t5_checksum",    32'(checksum),    0);
    rd_addr = 6'd63;
    tick(1);
    check("t5_fb_unchanged", 32'(rd_data), 2);

    // ---- T3: queue overflow ------------------------------------------------
    do_reset();
    for (int i = 0; i < 15; i++) push(3'((i % 7) + 1));
    check("t3_not_full_15", 32'(q_full), 0);
    push(3'((15 % 7) + 1));
    check("t3_full_16",     32'(q_full), 1);
    check("t3_no_error_16", 32'(error),  0);
    push(CMD_MIRROR_Y);
    check("t3_error_17",    32'(error),  1);
    check("t3_still_full",  32'(q_full), 1);
    bus_if.busy = 1'b0;
    pulse_start();
    for (int i = 0; i < 16; i++) wait_cmd(3'((i % 7) + 1), $sformatf("t3_c%0d", i), 1'b1, 2);
    // The dropped 17th entry (MIRROR_Y) must not appear: next is the auto write.
    wait_cmd(CMD_WRITE, "t3_auto", 1'b0, 0);
    check("t3_drained", 32'(q_full), 0);

    // ---- T4: busy stuck high -> timeout ------------------------------------
    do_reset();
    push(CMD_LEFT);
    pulse_start();
    wait_cmd(CMD_LEFT, "t4_cmd", 1'b1, 0);
    tick(1024);
    check("t4_no_error_1025", 32'(error),       0);
    check("t4_not_fin_1025",  32'(frame_valid), 0);
    tick(1);
    check("t4_error_1026",    32'(error),       1);
    check("t4_fin_1026",      32'(frame_valid), 1);
    cnt = 0;
    repeat (74) begin
      @(negedge clk);
      if (bus_if.cmd_valid) cnt++;
    end
    bus_if.busy = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus_if.cmd_valid) cnt++;
    end
    check("t4_no_cmd_after_timeout", 32'(cnt), 0);
    check("t4_error_sticky",         32'(error), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
